// File: rtl/a2g_rx_pkg.sv
// a2g_rx_pkg
// Shared definitions for the a2g rx_full status path.
//   - Bit positions of the fields inside the 32-bit rx_full status word.
//   - Width of the overflow-count field.
//   - sat_inc(): increment that holds at the all-ones value of a given width.
package a2g_rx_pkg;

  localparam int STICKY_BIT   = 31;
  localparam int FULL_NOW_BIT = 30;
  localparam int OVF_LSB      = 16;
  localparam int HWM_LSB      = 0;
  localparam int OVF_FIELD_W  = 12;
  localparam int HWM_FIELD_W  = 16;

  // Increment value by one unless it already sits at the all-ones value of
  // 'width' bits (width 1..32). Callers cast the result back to their width.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input int unsigned width);
    logic [31:0] max_val;
    if (width >= 32) begin
      max_val = 32'hFFFF_FFFF;
    end else begin
      max_val = (32'd1 << width) - 32'd1;
    end
    if (value >= max_val) begin
      return max_val;
    end
    return value + 32'd1;
  endfunction

endpackage

// File: rtl/a2g_sat_counter.sv
// a2g_sat_counter
// Parameterised saturating event counter with synchronous clear.
// A clear and an event in the same cycle load 1: the event is never lost.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset (count -> 0)
//   i_clr    clear request (one cycle)
//   i_evt    count one event this cycle
//   o_count  current count, holds at all-ones
module a2g_sat_counter
  import a2g_rx_pkg::*;
#(
  parameter int W = 12
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_evt,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;
  logic [W-1:0] w_count_next;
  logic [W-1:0] w_count_inc;

  always_comb begin
    w_count_inc = W'(sat_inc(32'(r_count), W));
    if (i_clr) begin
      w_count_next = i_evt ? W'(1) : '0;
    end else if (i_evt) begin
      w_count_next = w_count_inc;
    end else begin
      w_count_next = r_count;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/a2g_rx_full_monitor.sv
// a2g_rx_full_monitor
// Watches the a2g receive FIFO in the user clock domain and builds the
// status word for the rx_full software register: sticky full flag, live
// full flag, saturating overflow count and fill high-water mark.
// Pipeline: inputs registered (stage 1), accumulators (stage 2), status
// word registered (stage 3). An input sampled at edge t shows on
// status_word after edge t+2.
// Ports:
//   user_clk     user/fabric clock
//   user_rst_n   asynchronous active-low reset
//   fifo_wr_en   FIFO write strobe
//   fifo_full    FIFO full flag
//   fifo_fill    FIFO occupancy (FILL_W bits)
//   sw_clr       software clear level; its rising edge clears the state
//   status_word  {sticky_full, full_now, 2'b0, ovf_cnt[11:0], hwm[15:0]}
//   ovf_pulse    one-cycle pulse per overflow event
//   full_cycles  (only with A2G_RX_FULL_CYCLES_EN) saturating count of
//                cycles the FIFO was full, same latency as status_word
module a2g_rx_full_monitor
  import a2g_rx_pkg::*;
#(
  parameter int FILL_W = 12,
  parameter int OVF_W  = 12
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic              fifo_wr_en,
  input  logic              fifo_full,
  input  logic [FILL_W-1:0] fifo_fill,
  input  logic              sw_clr,
  output logic [31:0]       status_word,
  output logic              ovf_pulse
`ifdef A2G_RX_FULL_CYCLES_EN
  ,
  output logic [31:0]       full_cycles
`endif
);

  // Stage 1: input registers
  logic              r_wr_q;
  logic              r_full_q;
  logic [FILL_W-1:0] r_fill_q;
  logic              r_clr_q;
  logic              r_clr_edge_d;
  logic              w_clr_edge;

  // Stage 2: accumulators
  logic              r_sticky_full;
  logic              r_full_now;
  logic [FILL_W-1:0] r_hwm;
  logic [FILL_W-1:0] w_hwm_next;
  logic [OVF_W-1:0]  w_ovf_cnt;
  logic              r_ovf_pulse;
  logic              w_event;

  // Stage 3: output register
  logic [31:0]       r_status_word;
  logic [31:0]       w_status_next;

  // The edge is registered so the clear lines up with the stage-1 data
  // that the accumulators consume one cycle later.
  assign w_clr_edge = sw_clr & ~r_clr_q;
  assign w_event    = r_wr_q & r_full_q;

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r_wr_q       <= 1'b0;
      r_full_q     <= 1'b0;
      r_fill_q     <= '0;
      r_clr_q      <= 1'b0;
      r_clr_edge_d <= 1'b0;
    end else begin
      r_wr_q       <= fifo_wr_en;
      r_full_q     <= fifo_full;
      r_fill_q     <= fifo_fill;
      r_clr_q      <= sw_clr;
      r_clr_edge_d <= w_clr_edge;
    end
  end

  // A clear restarts the high-water mark from the current fill level.
  always_comb begin
    if (r_clr_edge_d) begin
      w_hwm_next = r_fill_q;
    end else if (r_fill_q > r_hwm) begin
      w_hwm_next = r_fill_q;
    end else begin
      w_hwm_next = r_hwm;
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r_sticky_full <= 1'b0;
      r_full_now    <= 1'b0;
      r_hwm         <= '0;
      r_ovf_pulse   <= 1'b0;
    end else begin
      r_sticky_full <= r_full_q | (r_sticky_full & ~r_clr_edge_d);
      r_full_now    <= r_full_q;
      r_hwm         <= w_hwm_next;
      r_ovf_pulse   <= w_event;
    end
  end

  a2g_sat_counter #(
    .W (OVF_W)
  ) u_ovf_cnt (
    .i_clk   (user_clk),
    .i_rst_n (user_rst_n),
    .i_clr   (r_clr_edge_d),
    .i_evt   (w_event),
    .o_count (w_ovf_cnt)
  );

  always_comb begin
    w_status_next                            = '0;
    w_status_next[STICKY_BIT]                = r_sticky_full;
    w_status_next[FULL_NOW_BIT]              = r_full_now;
    w_status_next[OVF_LSB +: OVF_FIELD_W]    = OVF_FIELD_W'(w_ovf_cnt);
    w_status_next[HWM_LSB +: HWM_FIELD_W]    = HWM_FIELD_W'(r_hwm);
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r_status_word <= '0;
    end else begin
      r_status_word <= w_status_next;
    end
  end

  assign status_word = r_status_word;
  assign ovf_pulse   = r_ovf_pulse;

`ifdef A2G_RX_FULL_CYCLES_EN
  logic [31:0] w_full_cycles_cnt;
  logic [31:0] r_full_cycles;

  a2g_sat_counter #(
    .W (32)
  ) u_full_cycles (
    .i_clk   (user_clk),
    .i_rst_n (user_rst_n),
    .i_clr   (r_clr_edge_d),
    .i_evt   (r_full_q),
    .o_count (w_full_cycles_cnt)
  );

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r_full_cycles <= '0;
    end else begin
      r_full_cycles <= w_full_cycles_cnt;
    end
  end

  assign full_cycles = r_full_cycles;
`endif

endmodule
